matmul_addr_gen: RTL

Parametrised address generator for the matrix-multiply datapath. It replaces the fixed 8-bit RM2/RK2/RN2 increment/reset registers and the 3-to-1 compare muxes with one self-contained triple-loop sequencer. It produces DRAM addresses for operand A, operand B and result C, one inner-product term per `step`. The control unit drives `start` and `step` and consumes `lastK` and `done`. The address outputs feed the AR input path.

---
 rtl/matmul_addr_gen_pkg.sv | 13 +
 rtl/matmul_addr_gen_if.sv | 33 +++
 rtl/matmul_addr_gen_wrap_counter.sv | 26 ++
 rtl/matmul_addr_gen.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/matmul_addr_gen_pkg.sv
// Shared types and defaults for the matrix-multiply address generator.
package matmul_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIM_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/matmul_addr_gen_if.sv
// Control-unit <-> address-generator bus: job setup, stepping and address results.
interface matmul_addr_gen_if #(
    parameter int WIDTH = 8,
    parameter int DIM_W = 8
);
    logic             start;
    logic             step;
    logic [DIM_W-1:0] dimM;
    logic [DIM_W-1:0] dimK;
    logic [DIM_W-1:0] dimN;
    logic [WIDTH-1:0] baseA;
    logic [WIDTH-1:0] baseB;
    logic [WIDTH-1:0] baseC;
    logic             busy;
    logic [WIDTH-1:0] addrA;
    logic [WIDTH-1:0] addrB;
    logic [WIDTH-1:0] addrC;
    logic             lastK;
    logic             done;
    logic             cfgErr;

    // Control unit side
    modport master (
        output start, step, dimM, dimK, dimN, baseA, baseB, baseC,
        input  busy, addrA, addrB, addrC, lastK, done, cfgErr
    );

    // Address generator side
    modport slave (
        input  start, step, dimM, dimK, dimN, baseA, baseB, baseC,
        output busy, addrA, addrB, addrC, lastK, done, cfgErr
    );
endinterface

// File: rtl/matmul_addr_gen_wrap_counter.sv
// Loop index counter: counts 0..limit and wraps to 0 when enabled at limit.
module wrap_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] cnt,
    output logic             atLimit
);

    assign atLimit = (cnt == limit);

    // Index register; clear wins over enable so a new job always starts at 0.
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= atLimit ? '0 : cnt + WIDTH'(1);
    end

endmodule

// File: rtl/matmul_addr_gen.sv
// Triple-loop (i, j, k) address sequencer for C = A x B, all row-major.
// k is innermost; addresses are updated incrementally without multipliers.
module matmul_addr_gen
    import matmul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIM_W = DEF_DIM_W
) (
    input  logic               Clk,
    input  logic               Rst,
    matmul_addr_gen_if.slave   bus
);

    state_t           state, state_nxt;
    logic             accept, reject;
    logic             k_en, j_en, i_en;
    logic             k_at, j_at, i_at;
    logic [DIM_W-1:0] k_idx, j_idx, i_idx;
    logic [DIM_W-1:0] dim_m, dim_k, dim_n;
    logic [DIM_W-1:0] lim_m, lim_k, lim_n;
    logic [WIDTH-1:0] base_a, base_b, base_c;
    logic [WIDTH-1:0] row_a, row_nxt;
    logic [WIDTH-1:0] k_w, n_w;
    logic [WIDTH-1:0] addr_a, addr_b, addr_c;
    logic             cfg_err;
    logic             unused_i;

    assign lim_m = dim_m - DIM_W'(1);
    assign lim_k = dim_k - DIM_W'(1);
    assign lim_n = dim_n - DIM_W'(1);
    assign k_w   = WIDTH'(dim_k);
    assign n_w   = WIDTH'(dim_n);
    assign row_nxt = row_a + k_w;

    // Loop nesting: a level advances only when every inner level wraps.
    assign j_en = k_en & k_at;
    assign i_en = j_en & j_at;

    // The i index itself is never needed; only its wrap flag matters.
    assign unused_i = ^i_idx;

    wrap_counter #(.WIDTH(DIM_W)) u_k (
        .clk(Clk), .rst(Rst), .clr(accept), .en(k_en),
        .limit(lim_k), .cnt(k_idx), .atLimit(k_at)
    );
    wrap_counter #(.WIDTH(DIM_W)) u_j (
        .clk(Clk), .rst(Rst), .clr(accept), .en(j_en),
        .limit(lim_n), .cnt(j_idx), .atLimit(j_at)
    );
    wrap_counter #(.WIDTH(DIM_W)) u_i (
        .clk(Clk), .rst(Rst), .clr(accept), .en(i_en),
        .limit(lim_m), .cnt(i_idx), .atLimit(i_at)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state plus job accept/reject and step qualification.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        reject    = 1'b0;
        k_en      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.dimM == '0 || bus.dimK == '0 || bus.dimN == '0) begin
                        reject = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                k_en = bus.step;
                if (i_en && i_at)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Job configuration latched on an accepted start; cfgErr pulses on reject.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            dim_m   <= '0;
            dim_k   <= '0;
            dim_n   <= '0;
            base_a  <= '0;
            base_b  <= '0;
            base_c  <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= reject;
            if (accept) begin
                dim_m  <= bus.dimM;
                dim_k  <= bus.dimK;
                dim_n  <= bus.dimN;
                base_a <= bus.baseA;
                base_b <= bus.baseB;
                base_c <= bus.baseC;
            end
        end
    end

    // Address walk. The final term leaves addresses untouched so they hold
    // through DONE and IDLE.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            row_a  <= '0;
            addr_a <= '0;
            addr_b <= '0;
            addr_c <= '0;
        end else if (accept) begin
            row_a  <= '0;
            addr_a <= bus.baseA;
            addr_b <= bus.baseB;
            addr_c <= bus.baseC;
        end else if (k_en) begin
            if (!k_at) begin
                addr_a <= addr_a + WIDTH'(1);
                addr_b <= addr_b + n_w;
            end else if (!j_at) begin
                addr_a <= base_a + row_a;
                addr_b <= base_b + WIDTH'(j_idx) + WIDTH'(1);
                addr_c <= addr_c + WIDTH'(1);
            end else if (!i_at) begin
                row_a  <= row_nxt;
                addr_a <= base_a + row_nxt;
                addr_b <= base_b;
                addr_c <= addr_c + WIDTH'(1);
            end
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == DONE);
    assign bus.lastK  = (state == RUN) && (k_idx == lim_k);
    assign bus.cfgErr = cfg_err;
    assign bus.addrA  = addr_a;
    assign bus.addrB  = addr_b;
    assign bus.addrC  = addr_c;

endmodule
